// File: rtl/stream_mem_loader_pkg.sv
// Shared types and constants for the framed RAM program loader.
package stream_mem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CSUM  = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_TMO   = 2'd3;

endpackage

// File: rtl/stream_mem_loader_if.sv
// Byte stream in (valid/ready) and RAM word write port (we held until ready).
interface stream_mem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;

    modport master (
        output in_valid, in_data, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/stream_mem_loader_boot_word_pack.sv
// Little-endian byte-to-word packer; word_full_o flags the load that completes a word.
// Combinational full flag so the FSM can request the write on the very next cycle.
module boot_word_pack #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_full_o
);
    localparam int BPW = DATA_W / 8;

    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] word_q, word_d;

    assign word_full_o = load_i && (cnt_q == 4'(BPW - 1));
    assign word_o      = word_q;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (load_i) begin
            // New bytes enter at the top so byte 0 ends up in bits [7:0].
            word_d = (word_q >> 8) | (DATA_W'(byte_i) << (DATA_W - 8));
            cnt_d  = word_full_o ? 4'd0 : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/stream_mem_loader.sv
// Decodes A5/addr/count/payload/checksum packets into RAM word writes and gates core reset.
// Write issued the cycle after a word's last byte; in_ready drops while a write is pending.
module stream_mem_loader
    import stream_mem_loader_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic                clk,
    input  logic                rst,
    stream_mem_loader_if.slave  bus,
    output logic                core_rst,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code
);
    localparam int                BPW        = DATA_W / 8;
    localparam int                AB         = ADDR_W / 8;
    localparam int                TW         = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BPW - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       k_q, k_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic [7:0]        sum_q, sum_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              in_ready_q, in_ready_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic              acc;
    logic              timed;
    logic              pk_load, pk_clear, pk_full;
    logic [DATA_W-1:0] pk_word;

    boot_word_pack #(.DATA_W(DATA_W)) u_pack (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (pk_clear),
        .load_i      (pk_load),
        .byte_i      (bus.in_data),
        .word_o      (pk_word),
        .word_full_o (pk_full)
    );

    assign acc   = bus.in_valid && in_ready_q;
    assign timed = (state_q == S_ADDR) || (state_q == S_COUNT) ||
                   (state_q == S_DATA) || (state_q == S_CSUM);

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = (state_q == S_WRITE);
    assign bus.mem_addr  = waddr_q;
    assign bus.mem_wdata = pk_word;
    assign core_rst      = core_rst_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_code      = code_q;

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        bcnt_d     = bcnt_q;
        sum_d      = sum_q;
        tmo_d      = tmo_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        err_d      = err_q;
        code_d     = code_q;
        pk_load    = 1'b0;
        pk_clear   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                tmo_d = '0;
                if (acc && (bus.in_data == SYNC_BYTE)) begin
                    state_d    = S_ADDR;
                    core_rst_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    code_d     = ERR_NONE;
                    sum_d      = '0;
                    bcnt_d     = '0;
                    k_d        = '0;
                    pk_clear   = 1'b1;
                end
            end
            S_ADDR: begin
                if (acc) begin
                    waddr_d = (waddr_q >> 8) | (ADDR_W'(bus.in_data) << (ADDR_W - 8));
                    sum_d   = sum_q + bus.in_data;
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'(AB - 1)) begin
                        bcnt_d = '0;
                        if ((waddr_d & ALIGN_MASK) != '0) begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                            code_d  = ERR_ALIGN;
                        end else begin
                            state_d = S_COUNT;
                        end
                    end
                end
            end
            S_COUNT: begin
                if (acc) begin
                    cnt_d  = {bus.in_data, cnt_q[15:8]};
                    sum_d  = sum_q + bus.in_data;
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd1) begin
                        bcnt_d  = '0;
                        state_d = (cnt_d == 16'd0) ? S_CSUM : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (acc) begin
                    pk_load = 1'b1;
                    sum_d   = sum_q + bus.in_data;
                    if (pk_full) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.mem_ready) begin
                    waddr_d = waddr_q + ADDR_W'(BPW);
                    k_d     = k_q + 16'd1;
                    state_d = ((17'(k_q) + 17'd1) < 17'(cnt_q)) ? S_DATA : S_CSUM;
                end
            end
            S_CSUM: begin
                if (acc) begin
                    if (bus.in_data == sum_q) begin
                        state_d    = S_DONE;
                        core_rst_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        code_d  = ERR_CSUM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Idle gap supervision; frozen while a write is outstanding.
        if (timed) begin
            if (acc) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                tmo_d   = '0;
                state_d = S_ERROR;
                err_d   = 1'b1;
                code_d  = ERR_TMO;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    assign in_ready_d = (state_d != S_WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            waddr_q    <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            bcnt_q     <= '0;
            sum_q      <= '0;
            tmo_q      <= '0;
            in_ready_q <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            bcnt_q     <= bcnt_d;
            sum_q      <= sum_d;
            tmo_q      <= tmo_d;
            in_ready_q <= in_ready_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end
endmodule
